// File: rtl/encrypter_in.sv
// Unpacks UART plaintext bytes LSB-first into (n_len-1)-bit words for FastModExp.
// Latency: n_len+1 sizing cycles, then one cycle per bit; EMIT holds the word until fme_ready.
module encrypter_in #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      n_key,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             rx_done_tick,
  input  logic [7:0]       rx_data,
  input  logic             fme_ready,
  output logic             word_valid,
  output logic [31:0]      word_out,
  output logic             last_word_tick,
  output logic             busy,
  output logic             done_tick,
  output logic             cfg_err,
  output logic             overrun_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIZING,
    S_WAIT_BYTE,
    S_PACK,
    S_EMIT,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]      r_nbuf;
  logic [5:0]       r_n_len;
  logic [LEN_W-1:0] r_bytes_left;
  logic [7:0]       r_byte_buf;
  logic             r_full;
  logic [7:0]       r_shift;
  logic [3:0]       r_byte_bits;
  logic [31:0]      r_word;
  logic [5:0]       r_bit_count;
  logic             r_last;
  logic             r_cfg_err;
  logic             r_overrun_err;

  logic             w_nbuf_zero;
  logic             w_cfg_bad;
  logic [5:0]       w_w;
  logic [5:0]       w_bit_count_nxt;
  logic [3:0]       w_byte_bits_nxt;
  logic             w_no_more;
  logic             w_take_byte;
  logic             w_rx_load;
  logic             w_rx_drop;

  assign w_nbuf_zero     = (r_nbuf == 32'd0);
  assign w_cfg_bad       = (r_n_len < 6'd2);
  assign w_w             = r_n_len - 6'd1;
  assign w_bit_count_nxt = r_bit_count + 6'd1;
  assign w_byte_bits_nxt = r_byte_bits - 4'd1;
  assign w_no_more       = (r_bytes_left == '0) && !r_full;
  assign w_take_byte     = (r_state == S_WAIT_BYTE) && r_full;
  // A byte landing on the same cycle the buffer drains is accepted, not dropped.
  assign w_rx_load       = rx_done_tick && (r_state != S_IDLE) && (!r_full || w_take_byte);
  assign w_rx_drop       = rx_done_tick && (r_state != S_IDLE) && r_full && !w_take_byte;

  assign cfg_err     = r_cfg_err;
  assign overrun_err = r_overrun_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    word_valid     = 1'b0;
    word_out       = 32'd0;
    last_word_tick = 1'b0;
    busy           = (r_state != S_IDLE);
    done_tick      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_SIZING;
      end
      S_SIZING: begin
        if (w_nbuf_zero) begin
          if (w_cfg_bad || (r_bytes_left == '0)) w_state_nxt = S_FINISH;
          else                                   w_state_nxt = S_WAIT_BYTE;
        end
      end
      S_WAIT_BYTE: begin
        if (r_full) w_state_nxt = S_PACK;
      end
      S_PACK: begin
        if (w_bit_count_nxt == w_w) w_state_nxt = S_EMIT;
        else if (w_byte_bits_nxt == 4'd0) w_state_nxt = w_no_more ? S_EMIT : S_WAIT_BYTE;
      end
      S_EMIT: begin
        word_valid = 1'b1;
        word_out   = r_word;
        if (fme_ready) begin
          last_word_tick = r_last;
          if (r_last)                  w_state_nxt = S_FINISH;
          else if (r_byte_bits != 4'd0) w_state_nxt = S_PACK;
          else                         w_state_nxt = S_WAIT_BYTE;
        end
      end
      S_FINISH: begin
        done_tick   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nbuf        <= 32'd0;
      r_n_len       <= 6'd0;
      r_bytes_left  <= '0;
      r_byte_buf    <= 8'd0;
      r_full        <= 1'b0;
      r_shift       <= 8'd0;
      r_byte_bits   <= 4'd0;
      r_word        <= 32'd0;
      r_bit_count   <= 6'd0;
      r_last        <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_take_byte) r_full <= 1'b0;
      if (w_rx_load) begin
        r_byte_buf   <= rx_data;
        r_full       <= 1'b1;
        r_bytes_left <= r_bytes_left - LEN_W'(1);
      end
      if (w_rx_drop) r_overrun_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_nbuf        <= n_key;
            r_bytes_left  <= msg_len;
            r_n_len       <= 6'd0;
            r_full        <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_overrun_err <= 1'b0;
          end
        end
        S_SIZING: begin
          if (!w_nbuf_zero) begin
            r_n_len <= r_n_len + 6'd1;
            r_nbuf  <= {1'b0, r_nbuf[31:1]};
          end else if (w_cfg_bad) begin
            r_cfg_err <= 1'b1;
          end else begin
            r_word      <= 32'd0;
            r_bit_count <= 6'd0;
          end
        end
        S_WAIT_BYTE: begin
          if (r_full) begin
            r_shift     <= r_byte_buf;
            r_byte_bits <= 4'd8;
          end
        end
        S_PACK: begin
          r_word[r_bit_count[4:0]] <= r_shift[0];
          r_shift     <= {1'b0, r_shift[7:1]};
          r_byte_bits <= w_byte_bits_nxt;
          r_bit_count <= w_bit_count_nxt;
          // Both exits into EMIT share this last-word condition.
          r_last      <= (w_byte_bits_nxt == 4'd0) && w_no_more;
        end
        S_EMIT: begin
          if (fme_ready) begin
            r_word      <= 32'd0;
            r_bit_count <= 6'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_encrypter_in.sv
// Scoreboard bench for encrypter_in: directed jobs push expected words, a negedge monitor pops them.
module tb_encrypter_in;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] n_key;
  logic [15:0] msg_len;
  logic        rx_done_tick;
  logic [7:0]  rx_data;
  logic        fme_ready;
  logic        word_valid;
  logic [31:0] word_out;
  logic        last_word_tick;
  logic        busy;
  logic        done_tick;
  logic        cfg_err;
  logic        overrun_err;

  always #5 clk = ~clk;

  encrypter_in #(.LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .n_key(n_key), .msg_len(msg_len),
    .rx_done_tick(rx_done_tick), .rx_data(rx_data), .fme_ready(fme_ready),
    .word_valid(word_valid), .word_out(word_out), .last_word_tick(last_word_tick),
    .busy(busy), .done_tick(done_tick), .cfg_err(cfg_err), .overrun_err(overrun_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_done = 0;
  int n_xfer = 0;
  int last_xfer_cyc = 0;
  int done_cyc = 0;
  logic seen_valid = 1'b0;
  logic [32:0] expq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid) seen_valid = 1'b1;
      if (word_valid && fme_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_word", word_out, 32'hFFFF_FFFF);
        end else begin
          logic [32:0] e;
          e = expq.pop_front();
          check("word_out", word_out, e[31:0]);
          check("last_word_tick", {31'd0, last_word_tick}, {31'd0, e[32]});
        end
        n_xfer++;
        last_xfer_cyc = cyc;
      end else if (last_word_tick) begin
        check("last_tick_without_xfer", {31'd0, last_word_tick}, 32'd0);
      end
      if (done_tick) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_job(input logic [31:0] n, input logic [15:0] len);
    n_key   = n;
    msg_len = len;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    tick(1);
    rx_done_tick = 1'b0;
  endtask

  task automatic push_word(input logic last, input logic [31:0] w);
    expq.push_back({last, w});
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) tick(1);
    check(name, n_done - d0, 1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget && !word_valid; i++) tick(1);
    check(name, {31'd0, word_valid}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word_valid"}, {31'd0, word_valid}, 32'd0);
    check({tag, "_word_out"}, word_out, 32'd0);
    check({tag, "_last_tick"}, {31'd0, last_word_tick}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done_tick"}, {31'd0, done_tick}, 32'd0);
    check({tag, "_cfg_err"}, {31'd0, cfg_err}, 32'd0);
    check({tag, "_overrun_err"}, {31'd0, overrun_err}, 32'd0);
  endtask

  initial begin
    int x0;
    int d0;
    rst = 1'b1; start = 1'b0; n_key = 32'd0; msg_len = 16'd0;
    rx_done_tick = 1'b0; rx_data = 8'd0; fme_ready = 1'b1;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(1);

    // 0xA5 into 7-bit words: 0x25, then the lone top bit.
    x0 = n_xfer;
    start_job(32'hC5, 16'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    push_word(1'b0, 32'h25);
    push_word(1'b1, 32'h01);
    tick(12);
    send_byte(8'hA5);
    wait_done("t1_done", 100);
    check("t1_xfers", n_xfer - x0, 2);
    check("t1_done_after_last", done_cyc - last_xfer_cyc, 1);
    check("t1_queue_empty", expq.size(), 0);
    check("t1_overrun", {31'd0, overrun_err}, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);

    // 8-bit words line up with bytes.
    x0 = n_xfer;
    start_job(32'h1FF, 16'd2);
    push_word(1'b0, 32'h3C);
    push_word(1'b1, 32'h7E);
    tick(14);
    send_byte(8'h3C);
    tick(20);
    send_byte(8'h7E);
    wait_done("t2_done", 100);
    check("t2_xfers", n_xfer - x0, 2);
    check("t2_queue_empty", expq.size(), 0);

    // Stalled FME; third back-to-back byte overruns; 0x44 completes the job.
    fme_ready = 1'b0;
    start_job(32'hC5, 16'd3);
    push_word(1'b0, 32'h11);
    push_word(1'b0, 32'h44);
    push_word(1'b0, 32'h10);
    push_word(1'b1, 32'h02);
    tick(15);
    rx_done_tick = 1'b1;
    rx_data = 8'h11; tick(1);
    rx_data = 8'h22; tick(1);
    rx_data = 8'h33; tick(1);
    rx_done_tick = 1'b0;
    wait_valid("t3_valid", 40);
    for (int i = 0; i < 20; i++) begin
      check("t3_stall_valid", {31'd0, word_valid}, 32'd1);
      check("t3_stall_word", word_out, 32'h11);
      tick(1);
    end
    check("t3_overrun", {31'd0, overrun_err}, 32'd1);
    fme_ready = 1'b1;
    tick(20);
    send_byte(8'h44);
    wait_done("t3_done", 100);
    check("t3_queue_empty", expq.size(), 0);
    check("t3_overrun_sticky", {31'd0, overrun_err}, 32'd1);

    // Empty message: sizing only.
    x0 = n_xfer;
    seen_valid = 1'b0;
    start_job(32'h1FF, 16'd0);
    check("t4_overrun_cleared", {31'd0, overrun_err}, 32'd0);
    wait_done("t4_done", 30);
    check("t4_xfers", n_xfer - x0, 0);
    check("t4_no_valid", {31'd0, seen_valid}, 32'd0);
    check("t4_cfg_err", {31'd0, cfg_err}, 32'd0);

    // n_key=1 is a bad modulus; next start clears the flag.
    x0 = n_xfer;
    start_job(32'h1, 16'd4);
    wait_done("t5_done", 30);
    check("t5_cfg_err", {31'd0, cfg_err}, 32'd1);
    check("t5_xfers", n_xfer - x0, 0);
    start_job(32'hC5, 16'd1);
    check("t5_cfg_cleared", {31'd0, cfg_err}, 32'd0);
    push_word(1'b0, 32'h00);
    push_word(1'b1, 32'h01);
    tick(12);
    send_byte(8'h80);
    wait_done("t5b_done", 100);
    check("t5b_queue_empty", expq.size(), 0);

    // Reset while a word is pending aborts without done_tick.
    fme_ready = 1'b0;
    start_job(32'hC5, 16'd1);
    tick(12);
    send_byte(8'hA5);
    wait_valid("t6_valid", 40);
    d0 = n_done;
    rst = 1'b1;
    tick(1);
    check_all_zero("t6_rst");
    rst = 1'b0;
    tick(3);
    check("t6_no_done", n_done - d0, 0);
    check("t6_idle_valid", {31'd0, word_valid}, 32'd0);
    fme_ready = 1'b1;
    x0 = n_xfer;
    start_job(32'hC5, 16'd1);
    push_word(1'b0, 32'h25);
    push_word(1'b1, 32'h01);
    tick(12);
    send_byte(8'hA5);
    wait_done("t6_fresh_done", 100);
    check("t6_fresh_xfers", n_xfer - x0, 2);
    check("t6_queue_empty", expq.size(), 0);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/encrypter_in.md
Name: encrypter_in

Overview:
Front end of the encryption path. Receives plaintext bytes from the UART receiver and unpacks them LSB-first into words of (n_len-1) bits, where n_len is the bit length of n_key. Each word is handed to FastModExp through a valid/ready handshake. It is the mirror of the decryption output packer: every chunk is strictly below 2^(n_len-1), so it is below n, and the packer strips exactly these bits on the way out.

Parameters:
LEN_W, 16, width of the message byte count msg_len.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle pulse; latches n_key and msg_len; ignored unless in IDLE
n_key  input  32  RSA modulus
msg_len  input  LEN_W  number of plaintext bytes to consume
rx_done_tick  input  1  one-cycle pulse; rx_data holds a valid byte
rx_data  input  8  received byte
fme_ready  input  1  FME can accept a word this cycle
word_valid  output  1  word_out holds a valid chunk
word_out  output  32  chunk, zero-extended above bit n_len-2
last_word_tick  output  1  high on the transfer cycle of the final word
busy  output  1  high in every state except IDLE
done_tick  output  1  one-cycle pulse at end of job
cfg_err  output  1  sticky; n_key < 2; cleared on start
overrun_err  output  1  sticky; byte arrived while buffer full; cleared on start

Behaviour:
- Reset: all outputs 0. All counters and buffers are cleared. State goes to IDLE. Reset is honoured in any state and aborts a job mid-operation with no done_tick.
- States: IDLE, SIZING, WAIT_BYTE, PACK, EMIT, FINISH.
- IDLE: on start, latch n_key into a shift buffer and msg_len into bytes_left. Clear n_len, cfg_err and overrun_err. Go to SIZING.
- SIZING: each cycle, if the buffer is nonzero, n_len += 1 and shift the buffer right by 1. When the buffer is zero, w = n_len-1.
  - If w == 0: set cfg_err and go to FINISH.
  - Else if bytes_left == 0: go to FINISH, no words are emitted.
  - Else clear word_reg and bit_count, go to WAIT_BYTE.
  - Latency is n_len+1 cycles.
- Byte buffer: single 8-bit register plus a full flag.
  - rx_done_tick while empty, in any state other than IDLE: load the buffer, set full, decrement bytes_left.
  - rx_done_tick while full: drop the byte and set overrun_err. bytes_left is unchanged.
  - In IDLE, rx bytes are ignored.
- WAIT_BYTE: when the buffer is full, move it to shift_reg, set byte_bits=8, clear full, go to PACK. Loading and clearing full in the same cycle are allowed.
- PACK: one bit per cycle.
  - word_reg[bit_count] = shift_reg[0]; shift_reg >>= 1; byte_bits -= 1; bit_count += 1.
  - If bit_count reaches w: go to EMIT. The word is marked last if byte_bits == 0 and bytes_left == 0 and the buffer is empty.
  - Else if byte_bits reaches 0:
    - If bytes_left == 0 and the buffer is empty: go to EMIT with a partial word (upper bits 0), marked last.
    - Otherwise go to WAIT_BYTE.
- EMIT: word_valid=1 and word_out=word_reg, held stable until a cycle with fme_ready=1 (the transfer cycle).
  - last_word_tick=1 on the transfer cycle of the last word only.
  - After transfer: clear word_reg and bit_count.
    - Last word: go to FINISH.
    - Else if byte_bits > 0: go to PACK.
    - Else: go to WAIT_BYTE.
  - Bytes keep arriving into the buffer during EMIT.
- FINISH: done_tick=1 for one cycle, go to IDLE. Both error flags stay set until the next start.
- start is ignored outside IDLE.

Test Plan:
- n_key=0xC5 (n_len=8, w=7), msg_len=1, byte 0xA5, fme_ready=1 -> word 0x25, then word 0x01 with last_word_tick; done_tick one cycle later; overrun_err=0.
- n_key=0x1FF (w=8), msg_len=2, bytes 0x3C then 0x7E -> words 0x3C, then 0x7E with last_word_tick; exactly 2 transfers.
- n_key=0xC5, msg_len=3, fme_ready held 0 for 20 cycles while bytes 0x11, 0x22, 0x33 arrive back-to-back -> word_valid stays 1 with word_out stable at 0x11; the third byte sets overrun_err=1 and is dropped.
- n_key=0x1FF, msg_len=0 -> done_tick after SIZING; word_valid never asserts; cfg_err=0.
- n_key=1 -> cfg_err=1, done_tick, no words; then start with n_key=0xC5 -> cfg_err cleared.
- rst asserted mid-EMIT (word_valid=1) -> next cycle all outputs are 0, busy=0, no done_tick; a fresh start completes normally.
